ascon_byte_loader: RTL and testbench
====================================

Name: ascon_byte_loader

Overview:
- Upstream input stage of the Ascon core.
- Receives a byte-serial command/data stream from the 8-bit tile I/O.
- Assembles the three 128-bit operand registers and the 3-bit operation mode.
- Issues a one-cycle operation_ready pulse to the core once a complete, valid frame is loaded and the core is idle.

Parameters:
- TIMEOUT_CYCLES, 255, max idle cycles between bytes of a frame before abort (used only with optional feature).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  in_byte holds a valid byte
- in_byte  input  8  command/data byte
- in_ready  output  1  loader accepts a byte this cycle
- core_busy  input  1  core not in its idle state
- reg0_128b  output  128  key (encrypt/decrypt)
- reg1_128b  output  128  nonce (encrypt/decrypt)
- reg2_128b  output  128  associated data / message block
- operation_mode  output  3  mode for core (0 idle, 1 enc, 2 dec, 3 hash, 4 xof, 5 cxof)
- operation_ready  output  1  one-cycle start pulse to core
- frame_err  output  1  one-cycle pulse on rejected command or timeout abort

Behaviour:
- Reset: state CMD. All outputs 0: reg*_128b, operation_mode, operation_ready, frame_err. in_ready = 1 after reset (CMD state). Shadow buffer and counters cleared. rst mid-frame discards the partial frame.
- A byte is consumed only on in_valid && in_ready. in_valid while in_ready = 0 is ignored; the byte is not consumed.
- States: CMD, LOAD, FIRE.
- CMD (in_ready = 1): consumed byte is the command.
  - bits[7:3] != 0, or mode 6/7: frame_err pulse next cycle, stay CMD.
  - mode 0: no payload, stay CMD, no pulse.
  - mode 1/2: byte pointer = 0, end = 47, go LOAD.
  - mode 3/4/5: pointer = 32, end = 47, go LOAD.
  - Latch mode into a pending-mode register.
- LOAD (in_ready = 1): byte at pointer k writes shadow register k/16, bits [8*(15-k%16)+7 : 8*(15-k%16)] (MSB-first).
  - Hash modes clear shadow reg0/reg1 on command accept.
  - On consuming byte k == end, go FIRE. Otherwise pointer increments by 1 (6-bit, no wrap beyond 47).
- FIRE (in_ready = 0):
  - core_busy = 0: copy shadow to reg0/1/2_128b and pending mode to operation_mode, assert operation_ready for exactly that cycle, go CMD.
  - core_busy = 1: hold in FIRE, outputs unchanged, until core_busy falls; fire in the first cycle it is low.
- Output registers change only at the fire cycle, so they stay stable for the whole core operation while the next frame loads into the shadow.
- Latency: operation_ready asserts the cycle after the last payload byte is consumed, if core_busy = 0.
- A command byte arriving in CMD in the same cycle as the fire pulse is impossible: in FIRE, in_ready = 0.

Optional Feature:
- Macro ASCON_LOADER_TIMEOUT_EN.
- Defined: an 8-bit idle counter runs in LOAD; it resets on each consumed byte. When it reaches TIMEOUT_CYCLES with no byte, the loader aborts: pulse frame_err, return to CMD, discard the shadow, leave outputs unchanged.
- Undefined: no counter; LOAD waits indefinitely.

Test Plan:
- Encrypt: cmd 0x01, then 48 bytes 0x00..0x2F, core_busy = 0 → reg0 = 0x000102..0F, reg1 = 0x1011..1F, reg2 = 0x2021..2F, operation_mode = 1, single operation_ready pulse one cycle after byte 0x2F.
- Hash: cmd 0x03, then 16 bytes 0xA0..0xAF → reg0 = reg1 = 0, reg2 = 0xA0A1..AF, mode = 3, pulse.
- Bad commands: 0x06 and 0x81 → frame_err pulse each, no operation_ready, stays CMD, outputs unchanged.
- Busy hold: complete an encrypt frame with core_busy = 1 for 5 cycles → in_ready = 0, no pulse; pulse on the first cycle core_busy = 0, and prior outputs stay stable until then.
- Reset mid-frame: rst after 20 bytes → all outputs 0, in_ready = 1; a following valid hash frame loads correctly.
- With ASCON_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES = 4: stall 4 cycles mid-frame → frame_err pulse, return to CMD, no operation_ready.

Source files
------------

// File: rtl/ascon_byte_loader.sv
// ascon_byte_loader: byte-serial frame loader feeding key/nonce/data and mode to the Ascon core.
// Optional idle-timeout abort in LOAD is enabled by defining ASCON_LOADER_TIMEOUT_EN.
module ascon_byte_loader #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   input  logic [7:0]   in_byte,
   output logic         in_ready,
   input  logic         core_busy,
   output logic [127:0] reg0_128b,
   output logic [127:0] reg1_128b,
   output logic [127:0] reg2_128b,
   output logic [2:0]   operation_mode,
   output logic         operation_ready,
   output logic         frame_err
);
   typedef enum logic [1:0] {CMD, LOAD, FIRE} state_t;
   state_t state, state_nx;
   logic [5:0] ptr;
   logic [2:0] mode_p, mode_q;
   logic [2:0][15:0][7:0] sh;
   logic [127:0] r0, r1, r2;
   logic take, fire, cmd_bad, abort;
   assign in_ready = state != FIRE;
   assign take = in_valid && in_ready;
   assign fire = state == FIRE && !core_busy;
   assign cmd_bad = in_byte[7:3] != 5'd0 || in_byte[2:1] == 2'b11;
   assign operation_ready = fire;
   // The fire cycle already presents the new frame so the core can sample it with the pulse.
   assign reg0_128b = fire ? sh[0] : r0;
   assign reg1_128b = fire ? sh[1] : r1;
   assign reg2_128b = fire ? sh[2] : r2;
   assign operation_mode = fire ? mode_p : mode_q;
`ifdef ASCON_LOADER_TIMEOUT_EN
   logic [7:0] idle;
   assign abort = state == LOAD && !take && idle == 8'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge clk or posedge rst)
      if (rst) idle <= '0;
      else idle <= (state != LOAD || take || abort) ? 8'd0 : idle + 8'd1;
`else
   localparam int unused_timeout = TIMEOUT_CYCLES;
   assign abort = 1'b0;
`endif
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= CMD;
      else state <= state_nx;
   always_comb begin
      state_nx = state;
      unique case (state)
         CMD:  state_nx = (take && !cmd_bad && in_byte[2:0] != 3'd0) ? LOAD : CMD;
         LOAD: state_nx = abort ? CMD : (take && ptr == 6'd47) ? FIRE : LOAD;
         FIRE: state_nx = core_busy ? FIRE : CMD;
         default: state_nx = CMD;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ptr <= '0;
         mode_p <= '0;
         mode_q <= '0;
         sh <= '0;
         r0 <= '0;
         r1 <= '0;
         r2 <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= (state == CMD && take && cmd_bad) || abort;
         if (state == CMD && take && !cmd_bad) begin
            mode_p <= in_byte[2:0];
            ptr <= in_byte[2:0] >= 3'd3 ? 6'd32 : 6'd0;
            if (in_byte[2:0] >= 3'd3) begin
               sh[0] <= '0;
               sh[1] <= '0;
            end
         end
         if (state == LOAD && take) begin
            sh[ptr[5:4]][~ptr[3:0]] <= in_byte;
            ptr <= ptr == 6'd47 ? ptr : ptr + 6'd1;
         end
         if (abort) sh <= '0;
         if (fire) begin
            r0 <= sh[0];
            r1 <= sh[1];
            r2 <= sh[2];
            mode_q <= mode_p;
         end
      end
endmodule

// File: tb/tb_ascon_byte_loader.sv
// tb_ascon_byte_loader: randomized scoreboard bench for ascon_byte_loader.
module tb_ascon_byte_loader;
`ifdef ASCON_LOADER_TIMEOUT_EN
   localparam int TO = 4;
`else
   localparam int TO = 255;
`endif
   logic clk, rst, in_valid, in_ready, core_busy, operation_ready, frame_err;
   logic [7:0] in_byte;
   logic [127:0] reg0_128b, reg1_128b, reg2_128b;
   logic [2:0] operation_mode;
   typedef struct packed {
      logic [2:0] m;
      logic [127:0] a, b, c;
   } exp_t;
   exp_t q[$];
   exp_t em;
   int err_exp, checks, errors;
   logic [386:0] prev, cur;

   ascon_byte_loader #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_byte(in_byte), .in_ready(in_ready),
      .core_busy(core_busy), .reg0_128b(reg0_128b), .reg1_128b(reg1_128b), .reg2_128b(reg2_128b),
      .operation_mode(operation_mode), .operation_ready(operation_ready), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b);
      int gap;
      bit done;
      gap = $urandom_range(0, 2);
      done = 0;
      in_valid = 0;
      repeat (gap) begin @(posedge clk); #1; end
      in_valid = 1;
      in_byte = b;
      for (int i = 0; i < 50 && !done; i++) begin
         done = in_ready;
         @(posedge clk); #1;
      end
      in_valid = 0;
      chk("byte_accepted", done, 1);
   endtask

   // Expected registers come straight from the payload: key, nonce, data are bytes 0-15, 16-31, 32-47 MSB first.
   task automatic frame(input logic [2:0] mode, input int busy_n, input bit pat);
      logic [7:0] p[48];
      exp_t e;
      int s;
      s = mode >= 3 ? 32 : 0;
      for (int i = 0; i < 48; i++)
         p[i] = i < s ? 8'h00 : pat ? (s == 32 ? 8'(8'hA0 + i - 32) : 8'(i)) : 8'($urandom);
      e.m = mode;
      for (int i = 0; i < 16; i++) begin
         e.a = {e.a[119:0], p[i]};
         e.b = {e.b[119:0], p[16 + i]};
         e.c = {e.c[119:0], p[32 + i]};
      end
      q.push_back(e);
      core_busy = busy_n > 0;
      send({5'd0, mode});
      for (int i = s; i < 48; i++) send(p[i]);
      if (busy_n > 0) begin
         for (int i = 0; i < busy_n; i++) begin
            chk("busy_hold", {in_ready, operation_ready}, 0);
            @(posedge clk); #1;
         end
         core_busy = 0;
         #1;
      end
      chk("fire_pulse", operation_ready, 1);
      chk("fire_in_ready", in_ready, 0);
      @(posedge clk); #1;
      chk("after_fire", {in_ready, operation_ready}, 2'b10);
   endtask

   task automatic bad(input logic [7:0] b);
      err_exp++;
      send(b);
      chk("bad_cmd_err", frame_err, 1);
      chk("bad_cmd_state", {in_ready, operation_ready}, 2'b10);
   endtask

   always @(negedge clk) begin
      cur = {operation_mode, reg0_128b, reg1_128b, reg2_128b};
      if (!rst) begin
         if (operation_ready) begin
            chk("ready_expected", q.size() > 0, 1);
            if (q.size() > 0) begin
               em = q.pop_front();
               chk("mode", operation_mode, em.m);
               chk("reg0", reg0_128b, em.a);
               chk("reg1", reg1_128b, em.b);
               chk("reg2", reg2_128b, em.c);
            end
         end else chk("outputs_stable", cur !== prev, 0);
         if (frame_err) begin
            chk("frame_err_expected", err_exp > 0, 1);
            if (err_exp > 0) err_exp--;
         end
      end
      prev = cur;
   end

   initial begin
      logic [7:0] b;
      clk = 0; rst = 1; in_valid = 0; in_byte = 0; core_busy = 0;
      checks = 0; errors = 0; err_exp = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_regs", reg0_128b | reg1_128b | reg2_128b, 0);
      chk("rst_ctl", {operation_mode, operation_ready, frame_err, in_ready}, 6'b000001);
      rst = 0;
      frame(3'd1, 0, 1);
      chk("enc_reg0", reg0_128b, 128'h000102030405060708090A0B0C0D0E0F);
      chk("enc_reg1", reg1_128b, 128'h101112131415161718191A1B1C1D1E1F);
      chk("enc_reg2", reg2_128b, 128'h202122232425262728292A2B2C2D2E2F);
      chk("enc_mode", operation_mode, 1);
      frame(3'd3, 0, 1);
      chk("hash_reg01", reg0_128b | reg1_128b, 0);
      chk("hash_reg2", reg2_128b, 128'hA0A1A2A3A4A5A6A7A8A9AAABACADAEAF);
      bad(8'h06);
      bad(8'h81);
      frame(3'd1, 5, 0);
      send(8'h00);
      chk("mode0_idle", {in_ready, frame_err}, 2'b10);
      send(8'h01);
      for (int i = 0; i < 20; i++) send(8'($urandom));
      rst = 1;
      #1;
      chk("midrst_regs", reg0_128b | reg1_128b | reg2_128b, 0);
      chk("midrst_ctl", {operation_mode, operation_ready, frame_err, in_ready}, 6'b000001);
      @(posedge clk); #1;
      rst = 0;
      frame(3'd3, 0, 0);
`ifdef ASCON_LOADER_TIMEOUT_EN
      send(8'h02);
      for (int i = 0; i < 5; i++) send(8'($urandom));
      repeat (3) begin @(posedge clk); #1; end
      chk("timeout_early", frame_err, 0);
      err_exp++;
      @(posedge clk); #1;
      chk("timeout_err", {frame_err, in_ready, operation_ready}, 3'b110);
      frame(3'd4, 0, 0);
`endif
      for (int n = 0; n < 25; n++) begin
         case ($urandom_range(0, 3))
            0: begin
               b = 8'($urandom);
               if (b[7:3] == 5'd0 && b[2:1] != 2'b11) b[7] = 1'b1;
               bad(b);
            end
            1: begin
               send(8'h00);
               chk("mode0_idle", {in_ready, frame_err}, 2'b10);
            end
            default: frame(3'($urandom_range(1, 5)), $urandom_range(0, 3), 0);
         endcase
      end
      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", q.size(), 0);
      chk("errs_drained", err_exp, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
